// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: nibble width, blank pattern
// and the active-low hex segment table ({g,f,e,d,c,b,a}).
package seg7_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [6:0]          seg
);

  always_comb begin
    seg = SEG_LUT[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with valid/ready frame input and
// tear-free commit at frame end. Optional macro: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]        in_dp,
  output logic [6:0]                   seg,
  output logic                         dp,
  output logic [NUM_DIGITS-1:0]        an
);

  localparam int PRE_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DATA_W = NIBBLE_W * NUM_DIGITS;

  logic [PRE_W-1:0]      prescaler_q, prescaler_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic                  tick;
  logic                  frame_end;
  logic                  accept;
  logic [NIBBLE_W-1:0]   cur_nibble;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            cur_seg;

  seg7_hex_decode u_decode (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  always_comb begin
    tick        = (prescaler_q == PRE_W'(REFRESH_DIV - 1));
    frame_end   = tick && (index_q == IDX_W'(NUM_DIGITS - 1));
    prescaler_d = tick ? '0 : prescaler_q + 1'b1;
    index_d     = index_q;
    if (tick) begin
      index_d = (index_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : index_q + 1'b1;
    end
  end

  // A new frame waits in the shadow regs until the scan wraps, so a digit
  // never shows half of an old frame and half of a new one.
  always_comb begin
    in_ready      = !pending_q && !rst;
    accept        = in_valid && in_ready;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    disp_data_d   = disp_data_q;
    disp_dp_d     = disp_dp_q;
    pending_d     = pending_q;
    if (accept) begin
      shadow_data_d = in_data;
      shadow_dp_d   = in_dp;
      pending_d     = 1'b1;
    end
    if (frame_end && pending_q) begin
      disp_data_d = shadow_data_q;
      disp_dp_d   = shadow_dp_q;
      pending_d   = 1'b0;
    end
  end

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        cur_nibble = disp_data_q[i*NIBBLE_W +: NIBBLE_W];
        cur_dp     = disp_dp_q[i];
      end
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zero_acc;

  // Walk down from the leftmost digit; a digit is a leading zero while
  // everything at and above it has a zero nibble and an unlit point.
  always_comb begin
    zero_acc  = 1'b1;
    lead_zero = '0;
    cur_blank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (disp_data_q[i*NIBBLE_W +: NIBBLE_W] == '0) && !disp_dp_q[i];
      lead_zero[i] = zero_acc && (i > 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (index_q == IDX_W'(i)) begin
        cur_blank = lead_zero[i];
      end
    end
  end
`else
  always_comb begin
    cur_blank = 1'b0;
  end
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    an_d  = '1;
    if (!cur_blank) begin
      seg_d = cur_seg;
      dp_d  = !cur_dp;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (index_q == IDX_W'(i)) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q   <= '0;
      index_q       <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      disp_data_q   <= '0;
      disp_dp_q     <= '0;
      pending_q     <= 1'b0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= '1;
    end else begin
      prescaler_q   <= prescaler_d;
      index_q       <= index_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      disp_data_q   <= disp_data_d;
      disp_dp_q     <= disp_dp_d;
      pending_q     <= pending_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit slot (legal >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  producer offers in_data/in_dp.
REQ-006 SHALL have port in_ready  output  1  block accepts a frame this cycle.
REQ-007 SHALL have port in_data  input  4*NUM_DIGITS  hex nibble per digit; nibble 0 is the rightmost digit.
REQ-008 SHALL have port in_dp  input  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port dp  output  1  decimal-point cathode, active-low.
REQ-011 SHALL have port an  output  NUM_DIGITS  digit anodes, active-low, one-hot-low when active.

Function
REQ-012 SHALL count prescaler 0..REFRESH_DIV-1 and wrap; tick = prescaler==REFRESH_DIV-1.
REQ-013 SHALL advance digit index on tick, wrapping NUM_DIGITS-1 -> 0; frame end = tick with index NUM_DIGITS-1.
REQ-014 SHALL drive in_ready = !pending && !rst.
REQ-015 SHALL, on in_valid && in_ready, capture in_data/in_dp into shadow regs and set pending next cycle.
REQ-016 SHALL, at frame end with pending set, copy shadow to display regs and clear pending in the same edge (tear-free update).
REQ-017 SHALL hold in_ready low while pending; in_valid during that time has no effect; producer holds data (valid/ready rule).
REQ-018 SHALL register seg/dp/an: outputs reflect index and display regs with 1-cycle latency.
REQ-019 SHALL decode hex, active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-020 SHALL drive an[i]=0 only for i == index, all others 1.

Reset
REQ-021 SHALL on rst clear prescaler, index, display regs, shadow regs and pending.
REQ-022 SHALL on rst set an all 1, seg=7F, dp=1; rst mid-frame discards any pending frame.

Configuration
REQ-023 SHALL, with SEG7_LEADING_ZERO_BLANK_EN defined, blank digit i (an[i]=1, seg=7F, dp=1) when i>0, nibbles i..NUM_DIGITS-1 are all zero and in_dp bits i..NUM_DIGITS-1 are all zero; digit 0 always shown.
REQ-024 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, show every digit including leading zeros; scan timing identical both ways.

Structure
REQ-025 SHALL place the 16-entry segment pattern constants, SEG_BLANK (7F) and the nibble width constant in package seg7_pkg.
REQ-026 SHALL implement hex-to-segment decode as combinational sub-module seg7_hex_decode (4-bit in, 7-bit out); scan/handshake logic in the top.

Verification (NUM_DIGITS=4, REFRESH_DIV=4)
REQ-027 SHALL check reset: rst 3 cycles -> an=1111, seg=7F, dp=1, in_ready=0 during, 1 the cycle after release.
REQ-028 SHALL check scan: idle after reset -> an 1110,1101,1011,0111 repeating, each held 4 cycles, seg=40 throughout.
REQ-029 SHALL check handshake: in_data=1234, in_dp=0010 accepted -> in_ready 0 until frame end; second offer ABCD ignored; after commit digit0 seg=19, digit1 seg=30 dp=0, digit3 seg=79; in_ready returns 1.
REQ-030 SHALL check decode: frames 0123,4567,89AB,CDEF -> every seg value matches REQ-019 on its digit.
REQ-031 SHALL check reset mid-operation: accept 5555, assert rst before frame end -> display stays 0000 after release, pending clear.
REQ-032 SHALL check macro build: in_data=0005 -> only an[0] ever low, seg=12; in_data=0105 -> digits 0..2 shown, digit 3 blank.
